buck_sim_pwm: RTL
=================

# buck_sim_pwm

Parametrised successor to the team's fixed two-phase buck-converter solver. It advances a discretised L-C-R companion model, one timestep per two clock cycles. The source is now a switch driven by an internal PWM counter with runtime duty and amplitude, instead of a hard-coded step. Fixed-point format and coefficients are generics, and an enable and a step strobe are added so downstream logging and DAC blocks can sample each solved timestep.

## Interface
- `INT_W`, 16: integer bits of the signed fixed-point word.
- `FRAC_W`, 16: fraction bits. `W = INT_W + FRAC_W`.
- `PWM_PERIOD`, 200: timesteps per PWM period. Must be ≥ 2.
- `K_TL`, 32'h0000_0083: T/L coefficient (signed, W bits).
- `K_C`, 32'h0002_0000: 2C/T companion coefficient.
- `K_V`, 32'h0000_E884: node-voltage conductance coefficient.
- `K_E`, 32'h0000_003B: source injection coefficient.
- `clk_i` in 1: sole clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `en_i` in 1: run request, level-sensitive.
- `vin_i` in W: signed source amplitude when the switch is closed.
- `duty_i` in 16: closed-switch timesteps per PWM period.
- `v_1_o` out W: switch-side voltage.
- `v_2_o` out W: output-node voltage.
- `i_l_o` out W: inductor current.
- `sw_o` out 1: current switch state.
- `step_o` out 1: one-cycle pulse when a timestep completes.
- `sat_o` out 1: sticky overflow flag. Present only with `BUCK_SIM_SAT_EN`; otherwise tied 0.

## Operation
- **Reset values**
  - All state registers, outputs, PWM counter and latched duty/amplitude are 0.
  - The FSM is in `IDLE`.
- **States and transitions**
  - `IDLE` → `PH_I` when `en_i` = 1.
  - `PH_I` → `PH_V` unconditionally.
  - `PH_V` → `PH_I` if `en_i` = 1, else → `IDLE`.
  - Dropping `en_i` mid-step never aborts the step: `PH_V` always follows `PH_I`.
- **`PH_I` update**
  - `i_l <= i_l + mul(v_1 - v_2, K_TL)`
  - `i_c <= mul(v_2, K_C) - i_c`
- **`PH_V` update**
  - `e = sw ? vin_l : 0`
  - `v_2 <= mul(i_l + i_c, K_V) + mul(e, K_E)`
  - `v_1 <= e`
  - PWM counter advances.
  - `step_o` asserts on the same edge.
- **Fixed-point arithmetic**
  - `mul(a,b)` is a signed W×W product, full 2W result, arithmetically shifted right by `FRAC_W`, keeping the low W bits.
  - Rounding is truncation toward −∞.
  - All add/sub results are W bits.
- **PWM**
  - Counter runs 0..`PWM_PERIOD-1` and wraps to 0.
  - `sw = (cnt < duty_l)`.
  - `duty_l` and `vin_l` latch `duty_i`/`vin_i` whenever the counter is 0 at the start of a `PH_V`, so mid-period input changes take effect at the next period.
  - `duty_i` = 0 gives a switch that is always open.
  - `duty_i` ≥ `PWM_PERIOD` gives a switch that is always closed.
- **Hold behaviour:** in `IDLE`, all state holds and `step_o` = 0.
- **Output mapping:** `v_1_o`, `v_2_o`, `i_l_o` and `sw_o` are direct register outputs.

## Timing
- Throughput: one timestep per 2 cycles while `en_i` is high.
- Start latency: `en_i` high in cycle n (FSM in `IDLE`) gives `PH_I` in n+1, `PH_V` in n+2.
  - New `v_2_o`/`v_1_o` and `step_o` = 1 are visible in cycle n+3.
- `sw_o` changes on the same edge as the `PH_V` that advances the counter.
- `rst_i` overrides everything in any state, including mid-step.
  - The next cycle shows reset values.
  - A partially computed step is discarded.

## Configuration
- `BUCK_SIM_SAT_EN` defined:
  - Every W-bit register update (`i_l`, `i_c`, `v_2`) that overflows clamps to `{1'b0,{W-1{1'b1}}}` or `{1'b1,{W-1{1'b0}}}`.
  - `sat_o` sets on the first clamp and stays set until `rst_i`.
- `BUCK_SIM_SAT_EN` undefined:
  - Results wrap modulo 2^W.
  - `sat_o` is constant 0 and no compare logic is generated.

## Test plan
- **Reset:** hold `rst_i` 3 cycles with `en_i` = 1 → all outputs 0, FSM `IDLE`, no `step_o`.
- **First step, switch closed:** `vin_i` = 32'h000A_0000, `duty_i` = 200, `en_i` = 1 from reset release → at first `step_o`, `v_1_o` = 32'h000A_0000, `v_2_o` = 32'h0000_024E, `i_l_o` = 0.
  - `step_o` then pulses every 2nd cycle.
- **Switch never closes:** `duty_i` = 0, `vin_i` = 10.0, run 1000 cycles → `v_1_o`, `v_2_o`, `i_l_o` and `sw_o` all stay 0.
- **PWM pattern and latching:** `duty_i` = 100, `PWM_PERIOD` = 200 → `sw_o` is high for 100 steps, then low for 100 steps, repeating.
  - Changing `duty_i` to 50 mid-period takes effect only at the next counter wrap.
- **Enable drop mid-step:** deassert `en_i` during `PH_I` → `PH_V` still executes and `step_o` fires once, then outputs hold.
  - Reasserting `en_i` resumes from the held state with no lost or duplicated update.
- **Overflow:** override `K_E` = 32'h0002_0000, `vin_i` = 32'h7FFF_0000, `duty_i` = 200.
  - With `BUCK_SIM_SAT_EN`: `v_2_o` = 32'h7FFF_FFFF and `sat_o` = 1 sticky.
  - Without `BUCK_SIM_SAT_EN`: `v_2_o` wraps negative and `sat_o` = 0.

Source files
------------

// File: rtl/buck_sim_pwm.sv
// Two-phase L-C-R companion-model solver with a PWM-switched source, one timestep per two clocks.
// Define BUCK_SIM_SAT_EN to clamp overflowing state updates and raise a sticky sat_o.
module buck_sim_pwm #(
  parameter int INT_W      = 16,
  parameter int FRAC_W     = 16,
  parameter int PWM_PERIOD = 200,
  parameter logic signed [INT_W+FRAC_W-1:0] K_TL = 32'h0000_0083,
  parameter logic signed [INT_W+FRAC_W-1:0] K_C  = 32'h0002_0000,
  parameter logic signed [INT_W+FRAC_W-1:0] K_V  = 32'h0000_E884,
  parameter logic signed [INT_W+FRAC_W-1:0] K_E  = 32'h0000_003B
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic signed [INT_W+FRAC_W-1:0]  vin_i,
  input  logic        [15:0]              duty_i,
  output logic signed [INT_W+FRAC_W-1:0]  v_1_o,
  output logic signed [INT_W+FRAC_W-1:0]  v_2_o,
  output logic signed [INT_W+FRAC_W-1:0]  i_l_o,
  output logic                            sw_o,
  output logic                            step_o,
  output logic                            sat_o
);
  localparam int W     = INT_W + FRAC_W;
  localparam int WW    = 2 * W + 2;
  localparam int CNT_W = $clog2(PWM_PERIOD);

  typedef logic signed [W-1:0]  word_t;
  typedef logic signed [WW-1:0] wide_t;
  typedef enum logic [1:0] {IDLE = 2'd0, PH_I = 2'd1, PH_V = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             do_i, do_v;
  word_t            i_l_q, i_l_d, i_c_q, i_c_d, v_1_q, v_1_d, v_2_q, v_2_d;
  word_t            vin_l_q, vin_l_d;
  logic [15:0]      duty_l_q, duty_l_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sw_q, sw_d, step_q, step_d;
`ifdef BUCK_SIM_SAT_EN
  logic             sat_q, sat_d;
`endif

  // Products are carried wide so a saturating build can see true overflow.
  function automatic wide_t mulw(input word_t a, input word_t b);
    logic signed [2*W-1:0] p;
    p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    return wide_t'(p >>> FRAC_W);
  endfunction

`ifdef BUCK_SIM_SAT_EN
  localparam word_t MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam word_t MIN_V = {1'b1, {(W-1){1'b0}}};

  function automatic logic ovf(input wide_t x);
    return (x > wide_t'(MAX_V)) || (x < wide_t'(MIN_V));
  endfunction

  function automatic word_t fit(input wide_t x);
    if (x > wide_t'(MAX_V)) return MAX_V;
    if (x < wide_t'(MIN_V)) return MIN_V;
    return x[W-1:0];
  endfunction
`else
  function automatic word_t fit(input wide_t x);
    return x[W-1:0];
  endfunction
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: PH_V always follows PH_I, so a dropped enable never aborts a step
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i) state_d = PH_I;
      PH_I:    state_d = PH_V;
      PH_V:    state_d = en_i ? PH_I : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Phase strobes
  always_comb begin
    do_i = (state_q == PH_I);
    do_v = (state_q == PH_V);
  end

  logic        cnt_zero, sw_e;
  logic [15:0] duty_e;
  word_t       vin_e, e_w, diff_w, sum_w;
  wide_t       i_l_n, i_c_n, v_2_n;

  // A period boundary uses the freshly latched duty/amplitude for its own step.
  always_comb begin
    cnt_zero = (cnt_q == '0);
    duty_e   = cnt_zero ? duty_i : duty_l_q;
    vin_e    = cnt_zero ? vin_i  : vin_l_q;
    sw_e     = 32'(cnt_q) < 32'(duty_e);
    e_w      = sw_e ? vin_e : '0;
    diff_w   = v_1_q - v_2_q;
    sum_w    = i_l_q + i_c_q;
    i_l_n    = wide_t'(i_l_q) + mulw(diff_w, K_TL);
    i_c_n    = mulw(v_2_q, K_C) - wide_t'(i_c_q);
    v_2_n    = mulw(sum_w, K_V) + mulw(e_w, K_E);
  end

  always_comb begin
    i_l_d    = i_l_q;
    i_c_d    = i_c_q;
    v_1_d    = v_1_q;
    v_2_d    = v_2_q;
    vin_l_d  = vin_l_q;
    duty_l_d = duty_l_q;
    cnt_d    = cnt_q;
    sw_d     = sw_q;
    step_d   = 1'b0;
`ifdef BUCK_SIM_SAT_EN
    sat_d    = sat_q;
`endif
    if (do_i) begin
      i_l_d = fit(i_l_n);
      i_c_d = fit(i_c_n);
`ifdef BUCK_SIM_SAT_EN
      sat_d = sat_q | ovf(i_l_n) | ovf(i_c_n);
`endif
    end
    if (do_v) begin
      v_2_d  = fit(v_2_n);
      v_1_d  = e_w;
      sw_d   = sw_e;
      step_d = 1'b1;
      cnt_d  = (cnt_q == CNT_W'(PWM_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
      if (cnt_zero) begin
        duty_l_d = duty_i;
        vin_l_d  = vin_i;
      end
`ifdef BUCK_SIM_SAT_EN
      sat_d = sat_q | ovf(v_2_n);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_l_q    <= '0;
      i_c_q    <= '0;
      v_1_q    <= '0;
      v_2_q    <= '0;
      vin_l_q  <= '0;
      duty_l_q <= '0;
      cnt_q    <= '0;
      sw_q     <= 1'b0;
      step_q   <= 1'b0;
`ifdef BUCK_SIM_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      i_l_q    <= i_l_d;
      i_c_q    <= i_c_d;
      v_1_q    <= v_1_d;
      v_2_q    <= v_2_d;
      vin_l_q  <= vin_l_d;
      duty_l_q <= duty_l_d;
      cnt_q    <= cnt_d;
      sw_q     <= sw_d;
      step_q   <= step_d;
`ifdef BUCK_SIM_SAT_EN
      sat_q    <= sat_d;
`endif
    end
  end

  assign v_1_o  = v_1_q;
  assign v_2_o  = v_2_q;
  assign i_l_o  = i_l_q;
  assign sw_o   = sw_q;
  assign step_o = step_q;
`ifdef BUCK_SIM_SAT_EN
  assign sat_o  = sat_q;
`else
  assign sat_o  = 1'b0;
`endif

endmodule
